cordic_angle_scheduler: RTL and testbench
=========================================

Name: cordic_angle_scheduler

Overview:
- Front-end controller for the iterative CORDIC rotation core.
- Accepts a sign-magnitude angle in degrees through a valid/ready handshake.
- Reduces the angle to the first quadrant [0, 90] and records the quadrant.
- Sequences the core through load plus ITERATIONS micro-steps, then applies quadrant and sign correction to the core's x/y outputs to produce cos/sin results, with backpressure.

Parameters:
- DATA_WIDTH, 20, width of the signed two's-complement core_x/core_y and cos_out/sin_out.
- PHI_WIDTH, 22, angle width: bit PHI_WIDTH-1 = sign, then 9 integer bits, then PHI_FRAC fraction bits, unsigned magnitude.
- PHI_FRAC, 12, fraction bits of the angle.
- ITERATIONS, 16, number of CORDIC micro-steps issued per request.
- ITER_W, 4, width of core_iter; ITER_W = clog2(ITERATIONS).

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  scheduler can accept a request.
- in_phi  in  PHI_WIDTH  sign-magnitude angle in degrees.
- core_load  out  1  one-cycle pulse: core loads initial x/y and core_phi.
- core_en  out  1  core performs micro-step core_iter this cycle.
- core_iter  out  ITER_W  micro-step index 0..ITERATIONS-1.
- core_phi  out  PHI_WIDTH-1  reduced unsigned magnitude, 0..90.0 degrees.
- core_x  in  DATA_WIDTH  core cosine of the reduced angle, valid in the FIX state.
- core_y  in  DATA_WIDTH  core sine of the reduced angle, valid in the FIX state.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- cos_out  out  DATA_WIDTH  corrected cosine.
- sin_out  out  DATA_WIDTH  corrected sine.
- quarter  out  2  quadrant of the magnitude: 0=Q1, 1=Q2, 2=Q3, 3=Q4; held with the result.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE and all registered outputs cleared.
  - in_ready=1; out_valid=0; core_load=0; core_en=0; core_iter=0; core_phi=0; cos_out=0; sin_out=0; quarter=0; busy=0.
  - Reset wins over everything; asserting it mid-request drops the request with no output.
- States: IDLE, REDUCE, LOAD, ROTATE, FIX, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch sign=in_phi[PHI_WIDTH-1] and m=in_phi[PHI_WIDTH-2:0], set q=0, go to REDUCE.
- REDUCE, one compare per cycle:
  - If m > 90<<PHI_FRAC: m -= 90<<PHI_FRAC, q = (q+1) mod 4, stay in REDUCE.
  - Otherwise go to LOAD.
  - m exactly 90.0 is not reduced. Maximum 5 subtractions, so REDUCE never exceeds 6 cycles.
- LOAD: core_load=1 for exactly this cycle; core_phi=m, held stable until IDLE; then go to ROTATE.
- ROTATE:
  - core_en=1 for ITERATIONS consecutive cycles, with core_iter=0,1,...,ITERATIONS-1.
  - After the core_iter=ITERATIONS-1 cycle, go to FIX. core_en is never high outside ROTATE.
- FIX: sample core_x (x) and core_y (y), compute the corrected result, register it, and go to OUT.
  - q=0: c=x, s=y.
  - q=1: c=-y, s=x.
  - q=2: c=-x, s=-y.
  - q=3: c=y, s=-x.
  - If sign=1: s=-s; c is unchanged.
  - Negation is two's complement at DATA_WIDTH, saturating: -(-2^(DATA_WIDTH-1)) = 2^(DATA_WIDTH-1)-1.
- OUT:
  - out_valid=1; cos_out, sin_out and quarter are held stable.
  - On out_ready: clear out_valid and go to IDLE.
  - in_ready stays 0 until IDLE, so there is no same-cycle accept of a new request.
- Latency: with k = number of subtractions, out_valid rises k+ITERATIONS+3 cycles after the accepting edge.
- in_phi and in_valid are ignored outside IDLE.
- A negative zero angle (sign=1, m=0) yields s=-y; with the core giving y=0, s=0.

Test Plan:
- Reset held, then released with in_valid=0 -> in_ready=1, out_valid=0, busy=0, all outputs 0; core_load/core_en never pulse.
- in_phi=+30.0 (m=0x1E000), core_x=0x0DDB3, core_y=0x08000:
  - core_load pulse with core_phi=0x1E000, then 16 core_en cycles with core_iter 0..15.
  - out_valid 19 cycles after accept; cos_out=0x0DDB3, sin_out=0x08000, quarter=0.
- in_phi=+120.0:
  - k=1, core_phi=30.0, quarter=1, out_valid after 20 cycles.
  - core_x=0x0DDB3, core_y=0x08000 -> cos_out=-0x08000, sin_out=0x0DDB3.
- in_phi=-200.0:
  - m reduces 200->110->20, so k=2, quarter=2, core_phi=20.0.
  - core_x=X, core_y=Y -> cos_out=-X, sin_out=+Y.
- Boundaries:
  - in_phi=+450.0: k=4, quarter wraps to 0, core_phi=90.0.
  - in_phi=+90.0: k=0, quarter=0, core_phi=90.0.
  - core_x=-2^19 with q=2 -> cos_out=2^19-1 (saturated).
- Backpressure and reset:
  - out_ready low for 5 cycles -> out_valid and the result stay stable, in_ready=0; on out_ready=1 -> IDLE next cycle.
  - rst_n pulsed low during ROTATE -> core_en=0 immediately, no out_valid; the next request completes normally.

Source files
------------

// File: rtl/cordic_angle_scheduler.sv
// ============================================================================
// Module  : cordic_angle_scheduler
// Brief   : Front-end controller for an iterative CORDIC rotation core.
//           Reduces a sign-magnitude angle to [0,90] degrees, sequences the
//           core, and applies quadrant/sign correction to cos/sin results.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cordic_angle_scheduler #(
  parameter int DATA_WIDTH = 20,
  parameter int PHI_WIDTH  = 22,
  parameter int PHI_FRAC   = 12,
  parameter int ITERATIONS = 16,
  parameter int ITER_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PHI_WIDTH-1:0]  in_phi,
  output logic                  core_load,
  output logic                  core_en,
  output logic [ITER_W-1:0]     core_iter,
  output logic [PHI_WIDTH-2:0]  core_phi,
  input  logic [DATA_WIDTH-1:0] core_x,
  input  logic [DATA_WIDTH-1:0] core_y,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] cos_out,
  output logic [DATA_WIDTH-1:0] sin_out,
  output logic [1:0]            quarter,
  output logic                  busy
);

  localparam logic [PHI_WIDTH-2:0] c_ninety    = (PHI_WIDTH-1)'(90 << PHI_FRAC);
  localparam logic [ITER_W-1:0]    c_last_iter = ITER_W'(ITERATIONS - 1);
  localparam logic [DATA_WIDTH-1:0] c_min_val  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REDUCE = 3'd1,
    S_LOAD   = 3'd2,
    S_ROTATE = 3'd3,
    S_FIX    = 3'd4,
    S_OUT    = 3'd5
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic                    r_sign;
  logic [PHI_WIDTH-2:0]    r_m;
  logic [1:0]              r_q;
  logic [ITER_W-1:0]       r_iter;
  logic [DATA_WIDTH-1:0]   r_cos;
  logic [DATA_WIDTH-1:0]   r_sin;
  logic                    w_reduce;
  logic [DATA_WIDTH-1:0]   w_c;
  logic [DATA_WIDTH-1:0]   w_s;
  logic [DATA_WIDTH-1:0]   w_cos;
  logic [DATA_WIDTH-1:0]   w_sin;

  // Two's-complement negate; the most negative value saturates to the maximum.
  function automatic logic [DATA_WIDTH-1:0] f_neg(input logic [DATA_WIDTH-1:0] v);
    return (v == c_min_val) ? ~v : (~v + DATA_WIDTH'(1));
  endfunction

  assign w_reduce = (r_m > c_ninety);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    core_load = 1'b0;
    core_en   = 1'b0;
    out_valid = 1'b0;
    busy      = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_REDUCE;
      end
      S_REDUCE: begin
        if (!w_reduce) w_next = S_LOAD;
      end
      S_LOAD: begin
        core_load = 1'b1;
        w_next    = S_ROTATE;
      end
      S_ROTATE: begin
        core_en = 1'b1;
        if (r_iter == c_last_iter) w_next = S_FIX;
      end
      S_FIX: begin
        w_next = S_OUT;
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_c = core_x;
    w_s = core_y;
    case (r_q)
      2'd0: begin w_c = core_x;        w_s = core_y;        end
      2'd1: begin w_c = f_neg(core_y); w_s = core_x;        end
      2'd2: begin w_c = f_neg(core_x); w_s = f_neg(core_y); end
      default: begin w_c = core_y;     w_s = f_neg(core_x); end
    endcase
    w_cos = w_c;
    w_sin = r_sign ? f_neg(w_s) : w_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign <= 1'b0;
      r_m    <= '0;
      r_q    <= '0;
      r_iter <= '0;
      r_cos  <= '0;
      r_sin  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sign <= in_phi[PHI_WIDTH-1];
            r_m    <= in_phi[PHI_WIDTH-2:0];
            r_q    <= 2'd0;
          end
        end
        S_REDUCE: begin
          if (w_reduce) begin
            r_m <= r_m - c_ninety;
            r_q <= r_q + 2'd1;
          end
        end
        S_ROTATE: begin
          // Wrap back to zero so core_iter reads 0 outside the rotation window.
          r_iter <= (r_iter == c_last_iter) ? '0 : (r_iter + ITER_W'(1));
        end
        S_FIX: begin
          r_cos <= w_cos;
          r_sin <= w_sin;
        end
        default: ;
      endcase
    end
  end

  assign core_iter = r_iter;
  assign core_phi  = r_m;
  assign quarter   = r_q;
  assign cos_out   = r_cos;
  assign sin_out   = r_sin;

endmodule

`default_nettype wire

// File: tb/tb_cordic_angle_scheduler.sv
// ============================================================================
// Module  : tb_cordic_angle_scheduler
// Brief   : Self-checking bench: directed and random angles against a
//           plain-arithmetic reference of the angle reduction and correction.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cordic_angle_scheduler;

  localparam int DW = 20;
  localparam int PW = 22;
  localparam int PF = 12;
  localparam int IT = 16;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_phi;
  logic          core_load;
  logic          core_en;
  logic [IW-1:0] core_iter;
  logic [PW-2:0] core_phi;
  logic [DW-1:0] core_x;
  logic [DW-1:0] core_y;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] cos_out;
  logic [DW-1:0] sin_out;
  logic [1:0]    quarter;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  cordic_angle_scheduler #(
    .DATA_WIDTH(DW), .PHI_WIDTH(PW), .PHI_FRAC(PF), .ITERATIONS(IT), .ITER_W(IW)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_phi(in_phi),
    .core_load(core_load), .core_en(core_en), .core_iter(core_iter), .core_phi(core_phi),
    .core_x(core_x), .core_y(core_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .cos_out(cos_out), .sin_out(sin_out), .quarter(quarter), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int sneg(input int v);
    return (v == -(1 << (DW-1))) ? ((1 << (DW-1)) - 1) : -v;
  endfunction

  // Reference: repeated subtraction of 90 degrees, then rotate the (x,y)
  // pair by q quarter turns and mirror sin for negative angles.
  task automatic model(input logic [PW-1:0] phi, input int x, input int y,
                       output int k, output int q, output int m,
                       output int c, output int s);
    int ninety;
    ninety = 90 * (1 << PF);
    m = int'(phi[PW-2:0]);
    k = 0;
    while (m > ninety) begin
      m = m - ninety;
      k++;
    end
    q = k % 4;
    case (q)
      0: begin c = x;       s = y;       end
      1: begin c = sneg(y); s = x;       end
      2: begin c = sneg(x); s = sneg(y); end
      default: begin c = y; s = sneg(x); end
    endcase
    if (phi[PW-1]) s = sneg(s);
  endtask

  function automatic logic [PW-1:0] deg(input bit neg, input int d);
    logic [PW-1:0] v;
    v = PW'(d) << PF;
    v[PW-1] = neg;
    return v;
  endfunction

  task automatic run_txn(input logic [PW-1:0] phi, input logic [DW-1:0] x,
                         input logic [DW-1:0] y, input int hold);
    int k, q, m, c, s, n, loads, ens;
    model(phi, int'($signed(x)), int'($signed(y)), k, q, m, c, s);
    core_x = x;
    core_y = y;
    check("idle_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_phi   = phi;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_phi   = PW'($urandom);
    n = 0; loads = 0; ens = 0;
    while (!out_valid && n < 60) begin
      if (core_load) begin
        loads++;
        check("load_cycle", 32'(n), 32'(k + 1));
        check("core_phi_load", 32'(core_phi), 32'(m));
      end
      if (core_en) begin
        if (ens == 0) check("rotate_start", 32'(n), 32'(k + 2));
        check("core_iter", 32'(core_iter), 32'(ens));
        ens++;
      end
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check("latency", 32'(n), 32'(k + IT + 3));
    check("load_count", 32'(loads), 32'd1);
    check("en_count", 32'(ens), 32'(IT));
    check("cos_out", 32'(cos_out), 32'(c) & 32'hFFFFF);
    check("sin_out", 32'(sin_out), 32'(s) & 32'hFFFFF);
    check("quarter", 32'(quarter), 32'(q));
    check("core_phi_held", 32'(core_phi), 32'(m));
    check("out_busy", {30'd0, in_ready, busy}, 32'd1);
    for (int i = 0; i < hold; i++) begin
      core_x = DW'($urandom);
      core_y = DW'($urandom);
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_cos", 32'(cos_out), 32'(c) & 32'hFFFFF);
      check("hold_sin", 32'(sin_out), 32'(s) & 32'hFFFFF);
      check("hold_q_ready", {29'd0, quarter, in_ready}, {29'd0, 2'(q), 1'b0});
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("release", {29'd0, out_valid, in_ready, busy}, 32'b010);
  endtask

  logic [DW-1:0] rx, ry;
  int            seen;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_phi = '0; out_ready = 1'b0;
    core_x = '0; core_y = '0;
    repeat (3) @(negedge clk);
    check("rst_ctl", {27'd0, in_ready, out_valid, busy, core_load, core_en}, 32'b10000);
    check("rst_data", {8'd0, cos_out | sin_out, core_iter}, 32'd0);
    check("rst_phi_q", {8'd0, core_phi, quarter}, 32'd0);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (core_load || core_en || out_valid || busy || !in_ready) seen++;
    end
    check("post_reset_quiet", 32'(seen), 32'd0);

    run_txn(deg(0, 30),  20'h0DDB3, 20'h08000, 0);
    run_txn(deg(0, 120), 20'h0DDB3, 20'h08000, 5);
    run_txn(deg(1, 200), DW'($urandom), DW'($urandom), 1);
    run_txn(deg(0, 450), DW'($urandom), DW'($urandom), 0);
    run_txn(deg(0, 90),  DW'($urandom), DW'($urandom), 0);
    run_txn(deg(0, 200), 20'h80000, DW'($urandom), 2);
    run_txn(deg(1, 0),   DW'($urandom), 20'h00000, 0);
    run_txn(deg(1, 511) | PW'(12'hFFF), 20'h80000, 20'h80000, 0);

    // Reset during rotation must abort without a result.
    in_valid = 1'b1; in_phi = deg(0, 30);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    seen = 0;
    while (!core_en && seen < 40) begin
      @(negedge clk);
      seen++;
    end
    check("reached_rotate", {31'd0, core_en}, 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_ctl", {27'd0, in_ready, out_valid, busy, core_load, core_en}, 32'b10000);
    check("abort_iter", 32'(core_iter), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (out_valid || core_en || busy) seen++;
    end
    check("no_output_after_abort", 32'(seen), 32'd0);
    run_txn(deg(1, 120), 20'h0DDB3, 20'h08000, 0);

    for (int t = 0; t < 40; t++) begin
      rx = DW'($urandom);
      ry = DW'($urandom);
      if ($urandom_range(0, 7) == 0) rx = 20'h80000;
      if ($urandom_range(0, 7) == 0) ry = 20'h80000;
      run_txn(PW'($urandom), rx, ry, int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
